// File: rtl/pwm_capture_if.sv
// PWM capture bus: the conditioned input side and the measurement result side.
interface pwm_capture_if #(
  parameter int unsigned COUNT_WIDTH = 17
);
  logic                   pwm_in;
  logic                   invert;
  logic [COUNT_WIDTH-1:0] high_count;
  logic [COUNT_WIDTH-1:0] period_count;
  logic                   valid;
  logic                   timeout;

  // Stimulus/consumer side.
  modport master (
    output pwm_in,
    output invert,
    input  high_count,
    input  period_count,
    input  valid,
    input  timeout
  );

  // Capture block side.
  modport slave (
    input  pwm_in,
    input  invert,
    output high_count,
    output period_count,
    output valid,
    output timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in
// system-clock cycles, with one result strobe per period or per stuck episode.
module pwm_capture #(
  parameter int unsigned COUNT_WIDTH = 17
) (
  input logic          clock,
  input logic          reset,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  logic s1_q, s2_q, s3_q;
  logic lvl, plvl, rise, fall;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] high_latch_q, high_latch_d;
  logic [COUNT_WIDTH-1:0] high_count_q, high_count_d;
  logic [COUNT_WIDTH-1:0] period_count_q, period_count_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   to_fire;
  logic                   stuck_level;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge decode on the active-level view of the synchronized input.
  always_comb begin
    lvl  = s2_q ^ bus.invert;
    plvl = s3_q ^ bus.invert;
    rise = lvl & ~plvl;
    fall = ~lvl & plvl;
  end

  // Measurement FSM, counter and result next-state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    high_latch_d   = high_latch_q;
    high_count_d   = high_count_q;
    period_count_d = period_count_q;
    valid_d        = 1'b0;
    timeout_d      = timeout_q;
    to_fire        = 1'b0;
    stuck_level    = 1'b0;

    // Counter restarts on every active edge; it only runs while measuring.
    if (rise) begin
      cnt_d = CntOne;
    end else if ((state_q != StIdle) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end

    unique case (state_q)
      StIdle: begin
        // First period after arming is incomplete, so no strobe here.
        if (rise) state_d = StHigh;
      end
      StHigh: begin
        if (fall) begin
          high_latch_d = cnt_q;
          state_d      = StLow;
        end else if (cnt_q == CntMax) begin
          to_fire     = 1'b1;
          stuck_level = 1'b1;
        end
      end
      StLow: begin
        // An edge on the saturation cycle wins over the timeout.
        if (rise) begin
          high_count_d   = high_latch_q;
          period_count_d = cnt_q;
          valid_d        = 1'b1;
          timeout_d      = 1'b0;
          state_d        = StHigh;
        end else if (cnt_q == CntMax) begin
          to_fire     = 1'b1;
          stuck_level = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stuck input: report once, then wait idle for the next active edge.
    if (to_fire) begin
      high_count_d   = stuck_level ? CntMax : '0;
      period_count_d = CntMax;
      valid_d        = 1'b1;
      timeout_d      = 1'b1;
      state_d        = StIdle;
    end
  end

  // State and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      high_latch_q   <= '0;
      high_count_q   <= '0;
      period_count_q <= '0;
      valid_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      high_latch_q   <= high_latch_d;
      high_count_q   <= high_count_d;
      period_count_q <= period_count_d;
      valid_q        <= valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.high_count   = high_count_q;
  assign bus.period_count = period_count_q;
  assign bus.valid        = valid_q;
  assign bus.timeout      = timeout_q;

endmodule
